acc_control_p: RTL and testbench
================================

Name: acc_control_p

Overview:
- Parametrised accumulator-machine control unit; next generation of the 4-bit single-cycle control block.
- Accepts 4-bit opcodes over a valid/ready handshake and executes them on accumulator Y and operand register Y1.
- Drives a variable-latency external memory through a req/ack interface with a timeout.
- Adds shift/XOR ops, a zero flag, port-out strobe and a sticky error flag; sits between the instruction source and data memory.

Parameters:
- DATA_W, 8, width of Y, Y1, port and memory data.
- ADDR_W, 6, memory address width.
- MEM_TIMEOUT, 15, max cycles mem_req held without mem_ack before abort; must be >=1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  unit can accept an instruction.
- instr  in  4  opcode.
- instr_addr  in  ADDR_W  address operand for LOAD/STORE.
- port_in  in  DATA_W  input port.
- port_out  out  DATA_W  output port register.
- port_out_vld  out  1  one-cycle strobe when port_out is written.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  stable while mem_req.
- mem_wdata  out  DATA_W  stable while mem_req.
- mem_rdata  in  DATA_W  read data, sampled on mem_ack.
- mem_ack  in  1  one-cycle completion.
- zero  out  1  Y == 0 after last ALU op or LOAD.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE. Y, Y1, port_out, zero and err are 0. port_out_vld, mem_req, mem_we are 0. mem_addr and mem_wdata are 0.
- States: IDLE, MEM.
- instr_ready = (state==IDLE).
- An instruction is accepted on a rising edge with instr_valid && instr_ready. Its effect is visible after that edge.
- Opcodes (op1=Y, op2=Y1, results mod 2^DATA_W):
  - 0 ADD: Y<=Y+Y1
  - 1 SUB: Y<=Y-Y1
  - 2 AND
  - 3 OR
  - 4 LOAD
  - 5 STORE
  - 6 IN: Y<=port_in
  - 7 OUT: port_out<=Y, port_out_vld=1 for exactly the next cycle
  - 8 MOV: Y1<=Y
  - 9 CLR: err<=0
  - 10 XOR
  - 11 SHL: Y<=Y<<1, LSB 0
  - 12 SHR: logical, MSB 0
  - 13-15 illegal: err<=1, no other state change
- Ops 0-3 and 10-12 are single-cycle and update zero from the new Y. IN, OUT, MOV and CLR do not touch zero.
- LOAD/STORE on acceptance: go to MEM, assert mem_req next cycle. mem_addr<=instr_addr; mem_we = 1 for STORE, 0 for LOAD; mem_wdata<=Y.
- In MEM, a cycle counter starts at 1 on the first req cycle.
- On mem_ack: mem_req<=0 and return to IDLE. For LOAD, Y<=mem_rdata and zero is updated.
- If the counter reaches MEM_TIMEOUT without ack: mem_req<=0, err<=1, return to IDLE, Y unchanged.
- ack in the same cycle as timeout expiry: ack wins, no error.
- mem_ack while IDLE is ignored.
- Minimum LOAD/STORE latency: 2 cycles from acceptance to instr_ready high again (ack on the first req cycle).
- rst_n asserted mid-MEM: mem_req drops immediately and the access is abandoned.
- instr_valid while busy: held off by instr_ready=0; the instruction is not lost.

Optional Feature:
- Macro: ACC_CARRY_EN.
- Defined:
  - Adds output carry (1 bit, reset 0).
  - ADD, SUB and SHL write the carry-out/borrow/shifted-out MSB to carry.
  - Opcode 13 ADC: Y<=Y+Y1+carry.
  - Opcode 14 SBB: Y<=Y-Y1-carry.
  - Opcode 15 remains illegal.
- Undefined: no carry port; 13-15 illegal.

Decomposition:
- Package acc_pkg: opcode localparams OP_ADD..OP_SBB, state encoding, ALU op-select type.
- One sub-module acc_alu (combinational): op1, op2, carry_in, opcode -> result, carry_out, zero.
- FSM, registers and memory timeout counter stay in acc_control_p.

Test Plan:
- IN with port_in=8'h05; MOV; IN 8'h03; ADD -> Y=8'h08, zero=0. Then SUB with Y1=8'h05 -> Y=8'h03.
- Y=8'hFF, Y1=8'h01, ADD -> Y=8'h00, zero=1. With ACC_CARRY_EN, carry=1; then ADC with Y1=0 -> Y=8'h01.
- STORE addr 6'h0A, Y=8'h5A; ack after 3 cycles -> mem_we=1, addr/wdata stable while req, instr_ready low 4 cycles. Then LOAD 6'h0A returning 8'h5A -> Y=8'h5A.
- LOAD with no ack, MEM_TIMEOUT=15 -> mem_req high exactly 15 cycles, then err=1, Y unchanged. Then CLR -> err=0.
- Opcode 4'hF -> err=1. Then OUT with Y=8'h3C -> port_out=8'h3C, port_out_vld high exactly 1 cycle.
- rst_n low for 1 cycle during MEM -> mem_req, Y, err all 0 immediately; instr_ready=1 after release.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator control unit: opcodes, FSM states
// and the ALU operation selector with its opcode decoder.
package acc_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;
  localparam logic [3:0] OP_IN    = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_MOV   = 4'd8;
  localparam logic [3:0] OP_CLR   = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;
  localparam logic [3:0] OP_SHL   = 4'd11;
  localparam logic [3:0] OP_SHR   = 4'd12;
  localparam logic [3:0] OP_ADC   = 4'd13;
  localparam logic [3:0] OP_SBB   = 4'd14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_ADC  = 4'd7,
    ALU_SBB  = 4'd8,
    ALU_PASS = 4'd9
  } alu_sel_e;

  function automatic alu_sel_e alu_sel_of(input logic [3:0] op);
    alu_sel_e sel;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_XOR:  sel = ALU_XOR;
      OP_SHL:  sel = ALU_SHL;
      OP_SHR:  sel = ALU_SHR;
      OP_ADC:  sel = ALU_ADC;
      OP_SBB:  sel = ALU_SBB;
      default: sel = ALU_PASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/acc_control_p_if.sv
// Instruction handshake and external memory bus of acc_control_p.
// master = instruction source / memory side, slave = the control unit.
interface acc_control_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output instr_valid, instr, instr_addr, mem_rdata, mem_ack,
    input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  instr_valid, instr, instr_addr, mem_rdata, mem_ack,
    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/acc_alu.sv
// Combinational ALU of the accumulator machine. carry_out is the carry for
// add-type ops, the borrow for subtract-type ops and the shifted-out MSB for SHL.
module acc_alu
  import acc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              carry_in,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero
);

  logic [DATA_W:0] ext_s;
  logic [DATA_W:0] cin_ext_s;

  assign cin_ext_s = {{DATA_W{1'b0}}, carry_in};

  // Result and carry/borrow selection; arithmetic runs one bit wider to catch the carry.
  always_comb begin
    ext_s     = '0;
    result    = op1;
    carry_out = 1'b0;
    case (alu_sel_of(opcode))
      ALU_ADD: begin
        ext_s     = {1'b0, op1} + {1'b0, op2};
        result    = ext_s[DATA_W-1:0];
        carry_out = ext_s[DATA_W];
      end
      ALU_ADC: begin
        ext_s     = {1'b0, op1} + {1'b0, op2} + cin_ext_s;
        result    = ext_s[DATA_W-1:0];
        carry_out = ext_s[DATA_W];
      end
      ALU_SUB: begin
        ext_s     = {1'b0, op1} - {1'b0, op2};
        result    = ext_s[DATA_W-1:0];
        carry_out = ext_s[DATA_W];
      end
      ALU_SBB: begin
        ext_s     = {1'b0, op1} - {1'b0, op2} - cin_ext_s;
        result    = ext_s[DATA_W-1:0];
        carry_out = ext_s[DATA_W];
      end
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_XOR: result = op1 ^ op2;
      ALU_SHL: begin
        result    = {op1[DATA_W-2:0], 1'b0};
        carry_out = op1[DATA_W-1];
      end
      ALU_SHR:  result = {1'b0, op1[DATA_W-1:1]};
      ALU_PASS: result = op1;
      default:  result = op1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/acc_control_p.sv
// Accumulator-machine control unit: instruction FSM, Y/Y1 registers and a
// req/ack memory port with timeout. Define ACC_CARRY_EN for the carry flag and ADC/SBB.
module acc_control_p
  import acc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_control_p_if.slave    bus,
  input  logic [DATA_W-1:0] port_in,
  output logic [DATA_W-1:0] port_out,
  output logic              port_out_vld,
  output logic              zero,
`ifdef ACC_CARRY_EN
  output logic              carry,
`endif
  output logic              err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] y1_q, y1_d;
  logic [DATA_W-1:0] port_out_q, port_out_d;
  logic              port_out_vld_q, port_out_vld_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_zero_s;
  logic              alu_cin_s;

`ifdef ACC_CARRY_EN
  logic              carry_q, carry_d;
  logic              alu_carry_s;
  assign alu_cin_s = carry_q;
`else
  logic              alu_carry_unused_s;
  assign alu_cin_s = 1'b0;
`endif

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op1       (y_q),
    .op2       (y1_q),
    .carry_in  (alu_cin_s),
    .opcode    (bus.instr),
`ifdef ACC_CARRY_EN
    .carry_out (alu_carry_s),
`else
    .carry_out (alu_carry_unused_s),
`endif
    .result    (alu_res_s),
    .zero      (alu_zero_s)
  );

  // Next-state logic: instruction decode in IDLE, ack/timeout tracking in MEM.
  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    y1_d           = y1_q;
    port_out_d     = port_out_q;
    port_out_vld_d = 1'b0;
    zero_d         = zero_q;
    err_d          = err_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cnt_d          = cnt_q;
`ifdef ACC_CARRY_EN
    carry_d        = carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          case (bus.instr)
            OP_ADD, OP_SUB, OP_SHL: begin
              y_d    = alu_res_s;
              zero_d = alu_zero_s;
`ifdef ACC_CARRY_EN
              carry_d = alu_carry_s;
`endif
            end
            OP_AND, OP_OR, OP_XOR, OP_SHR: begin
              y_d    = alu_res_s;
              zero_d = alu_zero_s;
            end
`ifdef ACC_CARRY_EN
            OP_ADC, OP_SBB: begin
              y_d    = alu_res_s;
              zero_d = alu_zero_s;
            end
`endif
            OP_LOAD, OP_STORE: begin
              state_d     = ST_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = (bus.instr == OP_STORE);
              mem_addr_d  = bus.instr_addr;
              mem_wdata_d = y_q;
              cnt_d       = CNT_W'(1);
            end
            OP_IN:  y_d = port_in;
            OP_OUT: begin
              port_out_d     = y_q;
              port_out_vld_d = 1'b1;
            end
            OP_MOV:  y1_d  = y_q;
            OP_CLR:  err_d = 1'b0;
            default: err_d = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MEM: begin
        // An ack in the expiry cycle still completes the access.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (!mem_we_q) begin
            y_d    = bus.mem_rdata;
            zero_d = (bus.mem_rdata == '0);
          end else begin
            y_d = y_q;
          end
        end else if (cnt_q == CNT_MAX) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      y_q            <= '0;
      y1_q           <= '0;
      port_out_q     <= '0;
      port_out_vld_q <= 1'b0;
      zero_q         <= 1'b0;
      err_q          <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cnt_q          <= '0;
`ifdef ACC_CARRY_EN
      carry_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      y_q            <= y_d;
      y1_q           <= y1_d;
      port_out_q     <= port_out_d;
      port_out_vld_q <= port_out_vld_d;
      zero_q         <= zero_d;
      err_q          <= err_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cnt_q          <= cnt_d;
`ifdef ACC_CARRY_EN
      carry_q        <= carry_d;
`endif
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign port_out        = port_out_q;
  assign port_out_vld    = port_out_vld_q;
  assign zero            = zero_q;
  assign err             = err_q;
`ifdef ACC_CARRY_EN
  assign carry           = carry_q;
`endif

endmodule

// File: tb/tb_acc_control_p.sv
// Self-checking bench for acc_control_p: directed scenarios then random
// instructions against an arithmetic reference model.
module tb_acc_control_p;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int TO = 15;

  localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_LOAD = 4'd4, T_STORE = 4'd5;
  localparam logic [3:0] T_IN = 4'd6, T_OUT = 4'd7, T_MOV = 4'd8, T_CLR = 4'd9;
  localparam logic [3:0] T_ADC = 4'd13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] port_in;
  logic [DW-1:0] port_out;
  logic          port_out_vld;
  logic          zero;
  logic          err;
`ifdef ACC_CARRY_EN
  logic          carry;
`endif

  acc_control_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  acc_control_p #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .port_in      (port_in),
    .port_out     (port_out),
    .port_out_vld (port_out_vld),
    .zero         (zero),
`ifdef ACC_CARRY_EN
    .carry        (carry),
`endif
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_y, m_y1, m_pout;
  logic       m_zero, m_err, m_carry;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 8'h00; m_y1 = 8'h00; m_pout = 8'h00;
    m_zero = 1'b0; m_err = 1'b0; m_carry = 1'b0;
  endtask

  // Reference behaviour of single-cycle instructions, written as plain arithmetic.
  task automatic model_step(input logic [3:0] op, input logic [7:0] pin);
    int s;
`ifdef ACC_CARRY_EN
    bit cen = 1'b1;
`else
    bit cen = 1'b0;
`endif
    case (op)
      4'd0:  begin s = int'(m_y) + int'(m_y1); m_carry = (s > 255); m_y = 8'(s); m_zero = (m_y == 8'h00); end
      4'd1:  begin m_carry = (m_y < m_y1); m_y = m_y - m_y1; m_zero = (m_y == 8'h00); end
      4'd2:  begin m_y = m_y & m_y1; m_zero = (m_y == 8'h00); end
      4'd3:  begin m_y = m_y | m_y1; m_zero = (m_y == 8'h00); end
      4'd6:  m_y = pin;
      4'd7:  m_pout = m_y;
      4'd8:  m_y1 = m_y;
      4'd9:  m_err = 1'b0;
      4'd10: begin m_y = m_y ^ m_y1; m_zero = (m_y == 8'h00); end
      4'd11: begin m_carry = m_y[7]; m_y = m_y * 8'd2; m_zero = (m_y == 8'h00); end
      4'd12: begin m_y = m_y / 8'd2; m_zero = (m_y == 8'h00); end
      4'd13: if (cen) begin
               s = int'(m_y) + int'(m_y1) + int'(m_carry); m_y = 8'(s); m_zero = (m_y == 8'h00);
             end else m_err = 1'b1;
      4'd14: if (cen) begin
               s = int'(m_y) - int'(m_y1) - int'(m_carry); m_y = 8'(s); m_zero = (m_y == 8'h00);
             end else m_err = 1'b1;
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic check_outputs(input string tag, input logic exp_vld);
    check({tag, "_zero"}, zero, m_zero);
    check({tag, "_err"}, err, m_err);
    check({tag, "_port_out"}, port_out, m_pout);
    check({tag, "_vld"}, port_out_vld, exp_vld);
    check({tag, "_ready"}, bus.instr_ready, 1'b1);
    check({tag, "_req_idle"}, bus.mem_req, 1'b0);
`ifdef ACC_CARRY_EN
    check({tag, "_carry"}, carry, m_carry);
`endif
  endtask

  task automatic exec(input logic [3:0] op, input logic [7:0] pin, input string tag);
    @(negedge clk);
    check({tag, "_vld_before"}, port_out_vld, 1'b0);
    check({tag, "_ready_before"}, bus.instr_ready, 1'b1);
    bus.instr_valid = 1'b1; bus.instr = op; bus.instr_addr = 6'($urandom); port_in = pin;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0; port_in = 8'($urandom);
    model_step(op, pin);
    @(negedge clk);
    check_outputs(tag, op == T_OUT);
  endtask

  // LOAD/STORE with ack on req cycle ack_at (0 or > TO: never acked).
  task automatic mem_op(input logic [3:0] op, input logic [5:0] addr, input int ack_at,
                        input logic [7:0] rd, input bit pend, input logic [7:0] pend_pin,
                        input string tag);
    int n = 0;
    bit done = 1'b0;
    logic [7:0] exp_wd;
    bit ok;
    @(negedge clk);
    check({tag, "_vld_before"}, port_out_vld, 1'b0);
    bus.instr_valid = 1'b1; bus.instr = op; bus.instr_addr = addr;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    exp_wd = m_y;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!bus.mem_req) begin
        done = 1'b1;
      end else begin
        n++;
        check({tag, "_addr"}, bus.mem_addr, addr);
        check({tag, "_we"}, bus.mem_we, op == T_STORE);
        check({tag, "_wdata"}, bus.mem_wdata, exp_wd);
        check({tag, "_busy"}, bus.instr_ready, 1'b0);
        bus.mem_ack = (n == ack_at);
        bus.mem_rdata = (n == ack_at) ? rd : 8'($urandom);
        if (pend && k == 0) begin
          bus.instr_valid = 1'b1; bus.instr = T_IN; port_in = pend_pin;
        end
      end
    end
    bus.mem_ack = 1'b0;
    check({tag, "_finished"}, done, 1'b1);
    ok = (ack_at >= 1 && ack_at <= TO);
    check({tag, "_req_cycles"}, n, ok ? ack_at : TO);
    if (ok && op == T_LOAD) begin
      m_y = rd; m_zero = (rd == 8'h00);
    end else if (!ok) begin
      m_err = 1'b1;
    end
    check_outputs(tag, 1'b0);
    if (pend) begin
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      model_step(T_IN, pend_pin);
      @(negedge clk);
      check_outputs({tag, "_pending"}, 1'b0);
    end
  endtask

  task automatic check_y(input string tag);
    exec(T_OUT, 8'h00, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    bus.instr_valid = 1'b0; bus.instr = 4'h0; bus.instr_addr = 6'h00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; port_in = 8'h00;
    model_reset();

    repeat (2) @(negedge clk);
    check_outputs("reset", 1'b0);
    check("reset_we", bus.mem_we, 1'b0);
    check("reset_addr", bus.mem_addr, 6'h00);
    check("reset_wdata", bus.mem_wdata, 8'h00);
    rst_n = 1'b1;

    exec(T_IN, 8'h05, "in5"); exec(T_MOV, 8'h00, "mov5");
    exec(T_IN, 8'h03, "in3"); exec(T_ADD, 8'h00, "add8");
    check_y("y_08");
    check("add8_value", port_out, 8'h08);
    exec(T_SUB, 8'h00, "sub5"); check_y("y_03");
    check("sub_value", port_out, 8'h03);

    exec(T_IN, 8'h01, "in1"); exec(T_MOV, 8'h00, "mov1");
    exec(T_IN, 8'hFF, "inff"); exec(T_ADD, 8'h00, "add_wrap");
    check("add_wrap_zero", zero, 1'b1);
`ifdef ACC_CARRY_EN
    check("add_wrap_carry", carry, 1'b1);
    exec(T_IN, 8'h00, "in0"); exec(T_MOV, 8'h00, "mov0");
    exec(T_ADC, 8'h00, "adc"); check_y("y_adc");
    check("adc_value", port_out, 8'h01);
`endif

    exec(T_IN, 8'h5A, "in5a");
    mem_op(T_STORE, 6'h0A, 4, 8'h00, 1'b0, 8'h00, "store");
    exec(T_IN, 8'h00, "clr_y");
    mem_op(T_LOAD, 6'h0A, 1, 8'h5A, 1'b0, 8'h00, "load");
    check_y("y_load"); check("load_value", port_out, 8'h5A);

    mem_op(T_LOAD, 6'h11, 0, 8'h00, 1'b0, 8'h00, "load_to");
    check("timeout_err", err, 1'b1);
    check_y("y_after_to");
    exec(T_CLR, 8'h00, "clr");
    mem_op(T_LOAD, 6'h12, TO, 8'h00, 1'b0, 8'h00, "ack_at_expiry");
    check("expiry_no_err", err, 1'b0);

    exec(4'hF, 8'h00, "illegal");
    check("illegal_err", err, 1'b1);
    exec(T_IN, 8'h3C, "in3c"); check_y("out3c");
    check("out3c_value", port_out, 8'h3C);

    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 8'hAA;
    @(negedge clk); bus.mem_ack = 1'b0;
    check_y("idle_ack_ignored");

    mem_op(T_STORE, 6'h3F, 3, 8'h00, 1'b1, 8'h99, "held_instr");
    check_y("y_held");

    exec(T_IN, 8'h77, "pre_rst"); exec(4'hE, 8'h00, "pre_rst_err");
    exec(4'hF, 8'h00, "pre_rst_err2");
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = T_LOAD; bus.instr_addr = 6'h05;
    @(posedge clk); #1; bus.instr_valid = 1'b0;
    @(negedge clk); check("midmem_req", bus.mem_req, 1'b1);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_zero", zero, 1'b0);
    @(negedge clk); rst_n = 1'b1; model_reset();
    @(negedge clk); check_outputs("after_rst", 1'b0);
    check_y("y_after_rst");

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == T_LOAD || op == T_STORE)
        mem_op(op, 6'($urandom), $urandom_range(0, 17), 8'($urandom), 1'b0, 8'h00, "rnd_mem");
      else
        exec(op, 8'($urandom), "rnd");
      if (i % 8 == 0) check_y("rnd_y");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
